// File: rtl/ex_muldiv.sv
// ex_muldiv: RV32M multiply/divide unit, radix-2 shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module ex_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   input  logic            hold,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MUL  = 3'd1;
   localparam logic [2:0] S_DIV  = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]      state;
   logic [CW-1:0]   cnt;
   logic [2:0]      op;
   logic            neg;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] opb;
   logic [XLEN-1:0] res;

   logic            sgn_a;
   logic            sgn_b;
   logic            neg_a;
   logic            neg_b;
   logic            neg_in;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            accept;
   logic            div_zero;
   logic            ovf;
   logic [XLEN-1:0] special;

   logic [XLEN:0]   sum;
   logic [XLEN:0]   shl;
   logic [XLEN-1:0] diff;
   logic            ge;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] fix_val;

   function automatic logic [XLEN-1:0] mul_sel(
      logic [2*XLEN-1:0] p,
      logic              n,
      logic [1:0]        f
   );
      logic [2*XLEN-1:0] s;
      s = n ? -p : p;
      return (f == 2'b00) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
   endfunction

   // Quotient takes sign(a)^sign(b); remainder keeps sign(a).
   always_comb begin
      sgn_a    = funct3[2] ? ~funct3[0] : ~(funct3[1] & funct3[0]);
      sgn_b    = funct3[2] ? ~funct3[0] : ~funct3[1];
      neg_a    = sgn_a & a[XLEN-1];
      neg_b    = sgn_b & b[XLEN-1];
      mag_a    = neg_a ? -a : a;
      mag_b    = neg_b ? -b : b;
      neg_in   = (funct3[2] & funct3[1]) ? neg_a : (neg_a ^ neg_b);
      div_zero = funct3[2] & (b == '0);
      ovf      = funct3[2] & ~funct3[0]
               & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
      if (div_zero)
         special = funct3[1] ? a : '1;
      else
         special = funct3[1] ? '0 : a;
      accept   = start & ((state == S_IDLE) | ((state == S_DONE) & ~hold));
   end

   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
      shl     = {hi, lo[XLEN-1]};
      ge      = (shl >= {1'b0, opb});
      diff    = shl[XLEN-1:0] - opb;
      quo     = neg ? -lo : lo;
      rem     = neg ? -hi : hi;
      fix_val = op[2] ? (op[1] ? rem : quo) : mul_sel({hi, lo}, neg, op[1:0]);
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   logic [XLEN-1:0]   fast_val;
   always_comb begin
      fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
      fast_val  = mul_sel(fast_prod, neg_in, funct3[1:0]);
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         op    <= '0;
         neg   <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         opb   <= '0;
         res   <= '0;
      end else if (kill) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  op  <= funct3;
                  neg <= neg_in;
                  cnt <= '0;
                  if (div_zero | ovf) begin
                     res   <= special;
                     state <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                  end else if (!funct3[2]) begin
                     res   <= fast_val;
                     state <= S_DONE;
`endif
                  end else if (funct3[2]) begin
                     hi    <= '0;
                     lo    <= mag_a;
                     opb   <= mag_b;
                     state <= S_DIV;
                  end else begin
                     hi    <= '0;
                     lo    <= mag_b;
                     opb   <= mag_a;
                     state <= S_MUL;
                  end
               end else if ((state == S_DONE) && !hold) begin
                  state <= S_IDLE;
               end
            end
            S_MUL: begin
               hi  <= sum[XLEN:1];
               lo  <= {sum[0], lo[XLEN-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == CW'(XLEN-1))
                  state <= S_FIX;
            end
            S_DIV: begin
               hi  <= ge ? diff : shl[XLEN-1:0];
               lo  <= {lo[XLEN-2:0], ge};
               cnt <= cnt + 1'b1;
               if (cnt == CW'(XLEN-1))
                  state <= S_FIX;
            end
            S_FIX: begin
               res   <= fix_val;
               state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy   = (state == S_MUL) | (state == S_DIV) | (state == S_FIX);
   assign done   = (state == S_DONE);
   assign result = done ? res : '0;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: vector table, corner sequences and random ops vs. arithmetic reference.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_ex_muldiv;

   localparam int XLEN     = 32;
   localparam int ITER_LAT = XLEN + 1;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 0;
`else
   localparam int MUL_LAT = ITER_LAT;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] a;
   logic [31:0] b;
   logic        kill;
   logic        hold;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   ex_muldiv #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .start(start), .funct3(funct3),
      .a(a), .b(b), .kill(kill), .hold(hold),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural definitions.
   function automatic logic [31:0] ref_op(input logic [2:0] f,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
      longint      sx;
      longint      sy;
      longint      uy;
      logic [63:0] ux;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      uy = longint'({32'b0, y});
      ux = {32'b0, x};
      case (f)
         3'd0: begin p = sx * sy; return p[31:0]; end
         3'd1: begin p = sx * sy; return p[63:32]; end
         3'd2: begin p = sx * uy; return p[63:32]; end
         3'd3: begin p = ux * {32'b0, y}; return p[63:32]; end
         3'd4: return (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
         3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: return (y == 0) ? x : 32'(sx % sy);
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x,
                                  input logic [31:0] y);
      if (!f[2])
         return MUL_LAT;
      if (y == 0)
         return 0;
      if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
         return 0;
      return ITER_LAT;
   endfunction

   // Launch at the next edge, scramble inputs, wait for done.
   task automatic run_op(input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y, output logic [31:0] res,
                         output int lat, output int bcyc, output bit leak);
      start  = 1'b1;
      funct3 = f;
      a      = x;
      b      = y;
      @(posedge clk); #1;
      start  = 1'b0;
      funct3 = 3'($urandom);
      a      = $urandom;
      b      = $urandom;
      lat    = 0;
      bcyc   = 0;
      leak   = 1'b0;
      while (!done && lat < 200) begin
         if (busy) bcyc++;
         if (result !== 32'h0) leak = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      res = result;
   endtask

   task automatic do_op(input string tag, input logic [2:0] f,
                        input logic [31:0] x, input logic [31:0] y);
      logic [31:0] res;
      int          lat;
      int          bcyc;
      bit          leak;
      int          el;
      el = ref_lat(f, x, y);
      run_op(f, x, y, res, lat, bcyc, leak);
      check({tag, " result"}, res, ref_op(f, x, y));
      check({tag, " latency"}, 32'(lat), 32'(el));
      check({tag, " busy cycles"}, 32'(bcyc), 32'(el));
      check({tag, " result leak"}, 32'(leak), 32'd0);
   endtask

   vec_t vecs[14];

   initial begin
      logic [31:0] res;
      logic [31:0] x;
      logic [31:0] y;
      int          lat;
      int          bcyc;
      bit          leak;
      bit          seen;

      vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
      vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT};
      vecs[2]  = '{3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, ITER_LAT};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, ITER_LAT};
      vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        ITER_LAT};
      vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         ITER_LAT};
      vecs[8]  = '{3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF, 0};
      vecs[9]  = '{3'd7, 32'h1234,       32'd0,         32'h1234,      0};
      vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0};
      vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0};
      vecs[12] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 0};
      vecs[13] = '{3'd6, 32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 0};

      reset  = 1'b1;
      start  = 1'b0;
      kill   = 1'b0;
      hold   = 1'b0;
      funct3 = 3'd0;
      a      = 32'd0;
      b      = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset result", result, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].f, vecs[i].x, vecs[i].y, res, lat, bcyc, leak);
         check($sformatf("vec%0d result", i), res, vecs[i].exp);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("vec%0d busy cycles", i), 32'(bcyc),
               32'(vecs[i].lat));
         check($sformatf("vec%0d result leak", i), 32'(leak), 32'd0);
         @(posedge clk); #1;
         check($sformatf("vec%0d back to idle", i), {30'b0, busy, done},
               32'd0);
      end

      // Hold in DONE for five cycles.
      run_op(3'd5, 32'd1000, 32'd9, res, lat, bcyc, leak);
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("hold%0d done", i), {31'b0, done}, 32'd1);
         check($sformatf("hold%0d result", i), result, 32'd111);
      end
      start  = 1'b1;
      funct3 = 3'd0;
      a      = 32'd3;
      b      = 32'd3;
      @(posedge clk); #1;
      check("start under hold ignored", {30'b0, busy, done}, 32'd1);
      start = 1'b0;
      hold  = 1'b0;
      @(posedge clk); #1;
      check("hold release idle", {30'b0, busy, done}, 32'd0);

      // Kill mid-divide at E10, new op accepted at E11.
      start  = 1'b1;
      funct3 = 3'd4;
      a      = 32'd1000;
      b      = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      seen  = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      check("kill busy", {31'b0, busy}, 32'd0);
      check("kill done", {31'b0, done}, 32'd0);
      check("kill no early done", 32'(seen), 32'd0);
      run_op(3'd5, 32'd100, 32'd7, res, lat, bcyc, leak);
      check("post-kill result", res, 32'd14);
      check("post-kill latency", 32'(lat), 32'(ITER_LAT));

      // Kill beats start while in DONE.
      start  = 1'b1;
      kill   = 1'b1;
      funct3 = 3'd5;
      a      = 32'd50;
      b      = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      kill  = 1'b0;
      check("kill over start", {30'b0, busy, done}, 32'd0);

      // Start while busy is ignored.
      start  = 1'b1;
      funct3 = 3'd7;
      a      = 32'd100;
      b      = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 0;
      repeat (3) begin
         @(posedge clk); #1;
         lat++;
      end
      start  = 1'b1;
      funct3 = 3'd0;
      a      = 32'd3;
      b      = 32'd3;
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      while (!done && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check("busy-start result", result, 32'd2);
      check("busy-start latency", 32'(lat), 32'(ITER_LAT));
      @(posedge clk); #1;

      // Asynchronous reset mid-divide.
      start  = 1'b1;
      funct3 = 3'd4;
      a      = 32'hFFFF_0000;
      b      = 32'd77;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async reset busy", {31'b0, busy}, 32'd0);
      check("async reset done", {31'b0, done}, 32'd0);
      check("async reset result", result, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      check("reset held idle", {30'b0, busy, done}, 32'd0);
      do_op("post-reset", 3'd7, 32'd100, 32'd7);
      @(posedge clk); #1;

      // Random ops, sometimes back-to-back from DONE.
      for (int i = 0; i < 60; i++) begin
         x = $urandom;
         y = $urandom;
         case ($urandom_range(6, 0))
            0: y = 32'd0;
            1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            2: y = 32'($urandom_range(15, 1));
            3: x = 32'($urandom_range(255, 0));
            default: ;
         endcase
         do_op($sformatf("rnd%0d", i), 3'($urandom), x, y);
         if ($urandom_range(1, 0) == 0) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
